// File: rtl/prio_slice_arbiter_if.sv
// Requester/arbiter signal bundle: request and release pulses in; owner code,
// FSM state and pre-emption count out.
interface prio_slice_arbiter_if #(
   parameter int N_CH  = 3,
   parameter int CNT_W = 16,
   parameter int ACC_W = $clog2(N_CH + 1)
);
   logic [N_CH-1:0]  req;
   logic [N_CH-1:0]  done;
   logic [ACC_W-1:0] accmodule;
   logic [3:0]       mstate;
   logic [CNT_W-1:0] nb_interrupts;

   modport master (
      output req, done,
      input  accmodule, mstate, nb_interrupts
   );

   modport slave (
      input  req, done,
      output accmodule, mstate, nb_interrupts
   );
endinterface

// File: rtl/prio_slice_arbiter.sv
// Shared-resource arbiter: channel 0 is the priority master with bounded pre-emption,
// channels 1..N_CH-1 are served round-robin with a fixed time slice.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | no owner, accmodule = 0
// S_PRI_FULL | channel 0 owns from idle, held until done[0]
// S_PRI_IT   | channel 0 pre-empted a low channel, bounded by IT_SLICE
// S_LO       | channel 1..N_CH-1 owns, bounded by SLICE
module prio_slice_arbiter #(
   parameter  int N_CH     = 3,
   parameter  int SLICE    = 2,
   parameter  int IT_SLICE = 2,
   parameter  int CNT_W    = 16,
   localparam int ACC_W    = $clog2(N_CH + 1),
   localparam int IDX_W    = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  reset,
   prio_slice_arbiter_if.slave   bus
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'b0001,
      S_PRI_FULL = 4'b0010,
      S_PRI_IT   = 4'b0100,
      S_LO       = 4'b1000
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [N_CH-1:0]    pend_q, pend_d;
   logic [CNT_W-1:0]   nb_q, nb_d;

   logic [N_CH-1:0]    own_mask, req_m, eff;
   logic               sel_valid, do_sel;
   logic [IDX_W-1:0]   sel_idx, cand;
   int                 c_scan;

   // A request from the owner, or one arriving with its own done, is dropped.
   assign own_mask = (state_q == S_IDLE) ? '0 : (N_CH'(1) << owner_q);
   assign req_m    = bus.req & ~bus.done & ~own_mask;
   assign eff      = req_m | pend_q;

   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      c_scan    = 0;
      cand      = '0;
      if (eff[0]) begin
         sel_valid = 1'b1;
      end else begin
         for (int k = 0; k < N_CH - 1; k++) begin
            c_scan = int'(rr_q) + k;
            if (c_scan > N_CH - 1) c_scan = c_scan - (N_CH - 1);
            cand = IDX_W'(c_scan);
            if (!sel_valid && eff[cand]) begin
               sel_valid = 1'b1;
               sel_idx   = cand;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q | req_m;
      nb_d    = nb_q;
      do_sel  = 1'b0;

      case (state_q)
         S_IDLE:     do_sel = 1'b1;
         S_PRI_FULL: do_sel = bus.done[0];
         S_PRI_IT: begin
            if (bus.done[0] || cnt_q == 4'd0) do_sel = 1'b1;
            else                              cnt_d  = cnt_q - 4'd1;
         end
         S_LO: begin
            if (bus.done[owner_q]) begin
               do_sel = 1'b1;
            end else if (eff[0]) begin
               state_d         = S_PRI_IT;
               owner_d         = '0;
               cnt_d           = 4'(IT_SLICE - 1);
               pend_d[owner_q] = 1'b1;
               pend_d[0]       = 1'b0;
               if (nb_q != '1) nb_d = nb_q + 1'b1;
            end else if (cnt_q == 4'd0) begin
               do_sel = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_sel) begin
         if (!sel_valid) begin
            state_d = S_IDLE;
            owner_d = '0;
         end else if (sel_idx == '0) begin
            state_d   = S_PRI_FULL;
            owner_d   = '0;
            pend_d[0] = 1'b0;
         end else begin
            state_d         = S_LO;
            owner_d         = sel_idx;
            cnt_d           = 4'(SLICE - 1);
            pend_d[sel_idx] = 1'b0;
            rr_d = (sel_idx == IDX_W'(N_CH - 1)) ? IDX_W'(1) : sel_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         rr_q    <= IDX_W'(1);
         cnt_q   <= '0;
         pend_q  <= '0;
         nb_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         nb_q    <= nb_d;
      end
   end

   assign bus.accmodule     = (state_q == S_IDLE) ? '0 : ACC_W'(owner_q) + ACC_W'(1);
   assign bus.mstate        = state_q;
   assign bus.nb_interrupts = nb_q;

endmodule
